// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: one registered
// command per cycle, read data routed back to the issuing port two cycles after accept.
module dm_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rd_data
);

  localparam int unsigned WAIT_W = 4;

  logic              last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              dm_re_q, dm_re_d;
  logic              dm_we_q, dm_we_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;

  logic              win_c;
  logic              accept_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  // Winner select: 0 = port 0, 1 = port 1.
  always_comb begin
    win_c = 1'b0;
    if (p0_req && p1_req) begin
      if (PRIO_MODE == 0) begin
        win_c = ~last_q;
      end else begin
        win_c = (wait_q == WAIT_W'(MAX_WAIT));
      end
    end else if (p1_req) begin
      win_c = 1'b1;
    end
  end

  assign p0_gnt      = rst_n & p0_req & ~win_c;
  assign p1_gnt      = rst_n & p1_req & win_c;
  assign accept_c    = p0_gnt | p1_gnt;
  assign sel_we_c    = win_c ? p1_we    : p0_we;
  assign sel_addr_c  = win_c ? p1_addr  : p0_addr;
  assign sel_wdata_c = win_c ? p1_wdata : p0_wdata;

  always_comb begin
    last_d      = last_q;
    wait_d      = wait_q;
    owner_d     = owner_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_re_d     = 1'b0;
    dm_we_d     = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;

    if (accept_c) begin
      last_d     = win_c;
      owner_d    = win_c;
      dm_addr_d  = sel_addr_c;
      dm_wdata_d = sel_wdata_c;
      dm_re_d    = ~sel_we_c;
      dm_we_d    = sel_we_c;
    end

    // Starvation guard counts refused port-1 cycles, saturating at MAX_WAIT.
    if (PRIO_MODE == 0 || !p1_req || p1_gnt) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Read data arrives after the negedge of the dm_re cycle; steer it to the owner.
    if (dm_re_q) begin
      if (owner_q) begin
        p1_rdata_d  = dm_rd_data;
        p1_rvalid_d = 1'b1;
      end else begin
        p0_rdata_d  = dm_rd_data;
        p0_rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b0;
      wait_q      <= '0;
      owner_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      dm_re_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      wait_q      <= wait_d;
      owner_q     <= owner_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_re_q     <= dm_re_d;
      dm_we_q     <= dm_we_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_re     = dm_re_q;
  assign dm_we     = dm_we_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter that shares the single-ported 1024x16 data memory between requesters.
- Port 0 is the CPU load/store path; port 1 is a secondary master such as a DMA or the SPART buffer.
- Issues at most one registered memory command per cycle, never asserting re and we together.
- Routes read data back to the issuing port with a fixed 2-cycle latency.

Parameters:
- ADDR_W, 10, memory word address width.
- DATA_W, 16, memory data width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to port 0 with starvation guard.
- MAX_WAIT, 4, PRIO_MODE=1 only: cycles port 1 may be refused before it is forced to win; range 1..15.

Ports:
- clk  in  1  system clock; all arbiter flops are posedge; the memory samples on negedge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; level, held until p0_gnt is seen.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  combinational accept for port 0 in the current cycle.
- p0_rdata  out  DATA_W  port 0 read data, registered.
- p0_rvalid  out  1  one-cycle pulse; p0_rdata is valid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid: same as port 0, for port 1.
- dm_addr  out  ADDR_W  memory address, registered.
- dm_re  out  1  memory read enable, registered.
- dm_we  out  1  memory write enable, registered.
- dm_wdata  out  DATA_W  memory write data, registered.
- dm_rd_data  in  DATA_W  memory read data; valid after the negedge of the cycle in which dm_re is high.

Behaviour:
- Reset (async, rst_n low) forces the following, independent of clk:
  - dm_re=0, dm_we=0, dm_addr=0, dm_wdata=0;
  - p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0;
  - rr pointer = port 0; wait counter = 0; all in-flight reads discarded.
- Handshake:
  - pX_gnt = pX_req & (winner==X); it is purely combinational.
  - Exactly one gnt can be high per cycle; no gnt is high while rst_n is low.
  - A request is accepted in cycle k when req&gnt. The requester may present a new request in k+1.
- Arbitration, PRIO_MODE=0:
  - With one requester, that port wins.
  - With both requesting, the port other than the last winner wins.
  - The pointer updates only on accept.
- Arbitration, PRIO_MODE=1:
  - Port 0 wins ties, except that port 1 wins when wait_cnt==MAX_WAIT.
  - wait_cnt increments each cycle p1_req is high and not granted, saturating at MAX_WAIT.
  - wait_cnt clears on a p1 accept, or whenever p1_req is low.
- Command stage: at the posedge ending accept cycle k:
  - dm_addr and dm_wdata take the winner's values;
  - dm_re = ~we; dm_we = we; owner flop = winner.
  - With no accept, dm_re=dm_we=0 and dm_addr/dm_wdata hold their values.
- Memory access: the memory acts on the negedge inside cycle k+1.
- Read return:
  - When dm_re is high in k+1, the posedge ending k+1 captures dm_rd_data into the owner's pX_rdata and pulses pX_rvalid in k+2.
  - Read latency is 2 cycles from accept; throughput is 1 access per cycle.
  - The non-owner's rdata holds its value.
- Ordering: a write accepted in k followed by a read of the same address accepted in k+1 returns the new data, because the write lands before the read negedge.
- Back-to-back: the same port may be accepted in consecutive cycles. Reads from both ports interleave, with each rvalid going only to its issuer.
- Reset mid-operation: an accepted-but-unreturned read produces no rvalid after reset release. The first post-reset grant follows the reset-state pointer.
- Invariant: dm_re & dm_we is never 1.

Test Plan:
- Reset, then p0 write addr 0x005=0xBEEF, then p0 read 0x005 -> p0_gnt in each accept cycle; dm_we=1 for one cycle, then dm_re=1; p0_rvalid 2 cycles after the read accept with p0_rdata=0xBEEF; p1_rvalid stays 0.
- PRIO_MODE=0, both ports read continuously (p0 addr 0x010, p1 addr 0x020, preloaded 0x1111/0x2222) -> gnt alternates p1,p0,p1,... (pointer starts at p0, so p1 wins the first tie); rvalids alternate with correct data; one dm_re per cycle.
- PRIO_MODE=1, MAX_WAIT=4, p0 and p1 requesting continuously -> p0 accepted 4 cycles, p1 accepted on the 5th; then the pattern repeats.
- p1 writes 0x3FF=0x1234 in cycle k, p0 reads 0x3FF in k+1 -> p0_rdata=0x1234 at k+3; address wrap to 0x3FF is handled without error.
- p0 read accepted, rst_n asserted low in the next cycle -> all outputs 0 immediately; no rvalid after release; the first tie after reset grants p1 (round-robin mode).
- Random 2-port traffic for 10k cycles against a scoreboard model -> dm_re&dm_we never both 1; every accepted read returns exactly one rvalid to its issuer with the model's data.
